uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver, 8N1, the receive-side counterpart of `uart_tx`. Synchronises the asynchronous serial input, detects and validates the start bit, samples each bit at its midpoint using the same `baud_div` clocks-per-bit programming as `uart_tx`, and presents each byte with a one-cycle valid strobe. It also flags framing errors and line breaks. It sits between the pad-side `rx` line and the byte-level consumer, and loops back directly against `uart_tx` for verification.

## Interface
- `baud_div` is a port, not a parameter; there are no parameters.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-low (`rst == 0` resets).
- `baud_div`  in  32  clock cycles per bit. Effective value is `max(baud_div, 2)`. Latched at start-bit detection.
- `rx`  in  1  asynchronous serial input; idle high.
- `rx_data`  out  8  last received byte; held until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when a frame with a good stop bit completes.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- **Synchroniser:** two flops `rx -> s1 -> rx_s`, both reset to 1. All decisions use `rx_s`.
- **Register reset:** `rx_data = 0x00`, `rx_valid = 0`, `frame_err = 0`, `rx_busy = 0`, state = IDLE, counters = 0.
- **Divider values:** `bd` = latched effective divider; `half = bd >> 1` (floor).
- **IDLE:** when `rx_s == 0`, latch `bd`, set `cnt = 0`, go to START.
- **START:** `cnt` increments each cycle. At `cnt == half`, re-check `rx_s`:
  - 0: set `cnt = 0`, `bit_idx = 0`, go to DATA.
  - 1 (glitch, false start): go to IDLE. No outputs pulse.
- **DATA:** `cnt` increments each cycle. At `cnt == bd-1`:
  - Shift `rx_s` into the shift register LSB-first (first data bit → bit 0), set `cnt = 0`.
  - After the 8th bit (`bit_idx == 7`), go to STOP; otherwise `bit_idx++`.
- **STOP:** at `cnt == bd-1`, load `rx_data` from the shift register in both cases, then:
  - `rx_s == 1`: pulse `rx_valid`, go to IDLE.
  - `rx_s == 0`: pulse `frame_err`, go to BREAK. `rx_valid` is not asserted.
- **BREAK:** remain until `rx_s == 1`, then go to IDLE. This prevents a held-low line from retriggering reception.
- `rx_valid` and `frame_err` are never high together.
- Changes to `baud_div` during a frame have no effect until the next start detection.
- Counter `cnt` is 32 bits and compares against `bd-1`; no wrap occurs because `bd >= 2`.

## Timing
- **Synchroniser latency:** 2 cycles.
- **Start detection:** IDLE exits on the first clock edge at which `rx_s` is 0.
- **Sample points:** relative to the IDLE→START edge (cycle T), the start re-check occurs at T+half+1. Data bit k (k = 0..7) is sampled at T+half+1+(k+1)·bd. The stop bit is sampled at T+half+1+9·bd.
- **Completion:** `rx_valid` / `frame_err` / `rx_data` update on the edge after the stop sample. Strobe pulses are exactly one cycle wide.
- **`rx_busy`:**
  - Rises the cycle after T.
  - Falls in the same cycle as the `rx_valid` strobe.
  - After a framing error, falls the cycle after `rx_s` returns high.
- **Back-to-back frames:** a start bit that begins immediately after the stop bit midpoint is detected. Returning to IDLE at the stop midpoint leaves half a bit of margin.
- **Reset mid-frame:** on the next edge with `rst == 0`, all state returns to reset values and no strobe is emitted. If `rx` is low when reset releases, the first frame starts from that low level.

## Test plan
- **Loopback:** `uart_tx` → `uart_rx`, `baud_div = 4`, send 0x55 then 0xA3 → two `rx_valid` pulses with `rx_data` = 0x55, then 0xA3; `frame_err` never asserts.
- **False start:** drive `rx` low for 1 cycle at `baud_div = 8` → return to IDLE; no `rx_valid`/`frame_err`; `rx_busy` high for at most half+2 cycles.
- **Framing error:** send 0x3C with a stop bit of 0, then hold `rx` low for 20 bit times → one `frame_err` pulse, `rx_data = 0x3C`, no `rx_valid`. `rx_busy` stays high until `rx` rises; no spurious second frame.
- **Reset mid-frame:** assert `rst = 0` during data bit 3 for 2 cycles, then send 0xF0 → no strobe from the aborted frame; next byte received as 0xF0; all outputs 0 during reset.
- **Back-to-back and divider:** three consecutive frames 0x00, 0xFF, 0x81 with no idle gap at `baud_div = 16` → three `rx_valid` pulses with correct data. Repeat with `baud_div = 1` while transmitting at 2 clocks/bit → correct reception (clamp to 2).
- **Mid-frame divider change:** change `baud_div` from 4 to 10 mid-frame → the current frame still decodes at 4.

Source files
------------

// File: rtl/uart_rx_if.sv
// +--------------------------------------------------------------------+
// | uart_rx_if : serial-side and byte-side signals of the UART receiver |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

interface uart_rx_if;
   logic [31:0] baud_div;
   logic        rx;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        rx_busy;

   modport slave (
      input  baud_div,
      input  rx,
      output rx_data,
      output rx_valid,
      output frame_err,
      output rx_busy
   );

   modport master (
      output baud_div,
      output rx,
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  rx_busy
   );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// +--------------------------------------------------------------------+
// | uart_rx  : 8N1 receiver, midpoint sampling, framing/break detection |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        s1_q, s1_d;
   logic        rx_s_q, rx_s_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] bd_q, bd_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        frame_err_q, frame_err_d;

   logic [31:0] bd_eff;
   logic [31:0] half;
   logic [31:0] bd_last;

   // Dividers below 2 would leave no room between start check and bit sample.
   assign bd_eff  = (bus.baud_div < 32'd2) ? 32'd2 : bus.baud_div;
   assign half    = bd_q >> 1;
   assign bd_last = bd_q - 32'd1;

   always_comb begin
      s1_d        = bus.rx;
      rx_s_d      = s1_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      bd_d        = bd_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               bd_d    = bd_eff;
               cnt_d   = 32'd0;
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (cnt_q == half) begin
               if (!rx_s_q) begin
                  cnt_d     = 32'd0;
                  bit_idx_d = 3'd0;
                  state_d   = ST_DATA;
               end else begin
                  state_d   = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         ST_DATA: begin
            if (cnt_q == bd_last) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               cnt_d   = 32'd0;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         ST_STOP: begin
            if (cnt_q == bd_last) begin
               rx_data_d = shift_q;
               cnt_d     = 32'd0;
               if (rx_s_q) begin
                  rx_valid_d  = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         // A line held low must not be mistaken for a new start bit.
         ST_BREAK: begin
            if (rx_s_q) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         s1_q        <= 1'b1;
         rx_s_q      <= 1'b1;
         cnt_q       <= 32'd0;
         bd_q        <= 32'd0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s1_q        <= s1_d;
         rx_s_q      <= rx_s_d;
         cnt_q       <= cnt_d;
         bd_q        <= bd_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.rx_busy   = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +--------------------------------------------------------------------+
// | tb_uart_rx : table vectors, corner sequences and random frames      |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx;

   localparam int MAXC = 60000;

   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_rx_if u_if ();

   uart_rx dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   logic drv_log [0:MAXC-1];
   int   div_log [0:MAXC-1];

   // kind: 1 = rx_valid, 2 = frame_err, 3 = both at once (never legal)
   typedef struct {
      int         kind;
      logic [7:0] data;
      int         at;
   } ev_t;

   ev_t obs_q [$];
   ev_t exp_q [$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         div;
      int         txd;
      int         exp_valid;
      int         exp_ferr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [8];

   // Logs the line level present at each rising edge and records strobes.
   int cur;
   always @(posedge clk) begin
      cur = edge_n;
      if (cur < MAXC) begin
         drv_log[cur] = u_if.rx;
         div_log[cur] = int'(u_if.baud_div);
      end
      edge_n = cur + 1;
      #1;
      if (u_if.rx_valid || u_if.frame_err) begin
         obs_q.push_back('{(u_if.rx_valid && u_if.frame_err) ? 3 : (u_if.rx_valid ? 1 : 2),
                           u_if.rx_data, cur});
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b, input int len);
      u_if.rx = b;
      repeat (len) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int txd);
      drive_bit(1'b0, txd);
      for (int i = 0; i < 8; i++) drive_bit(d[i], txd);
      drive_bit(stop, txd);
   endtask

   // Synchronised line as seen by the receiver at edge n: two flops of delay.
   function automatic logic rs(input int n);
      if (n < 2 || n - 2 >= MAXC) return 1'b1;
      return drv_log[n-2];
   endfunction

   // Decodes the logged line using the documented sample points.
   task automatic run_model(input int s, input int e);
      int n, t, bd, hf, ts;
      logic [7:0] b;
      exp_q.delete();
      n = s;
      while (n < e) begin
         if (!rs(n)) begin
            t  = n;
            bd = (div_log[t] < 2) ? 2 : div_log[t];
            hf = bd / 2;
            if (rs(t + hf + 1)) begin
               n = t + hf + 2;
            end else begin
               for (int k = 0; k < 8; k++) b[k] = rs(t + hf + 1 + (k + 1) * bd);
               ts = t + hf + 1 + 9 * bd;
               if (rs(ts)) begin
                  exp_q.push_back('{1, b, ts});
                  n = ts + 1;
               end else begin
                  exp_q.push_back('{2, b, ts});
                  n = ts + 1;
                  while (n < e && !rs(n)) n++;
                  n++;
               end
            end
         end else begin
            n++;
         end
      end
   endtask

   task automatic check_segment(input string name, input int s, input int base);
      int e, nobs;
      e    = edge_n;
      run_model(s, e);
      nobs = obs_q.size() - base;
      check($sformatf("%s events", name), nobs, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < nobs; i++) begin
         check($sformatf("%s ev%0d kind", name, i), obs_q[base+i].kind, exp_q[i].kind);
         check($sformatf("%s ev%0d data", name, i), obs_q[base+i].data, exp_q[i].data);
         check($sformatf("%s ev%0d cycle", name, i), obs_q[base+i].at, exp_q[i].at);
      end
   endtask

   initial begin
      int s, base, nv, nf, busy_cnt, dv, txd, gap;
      logic [7:0] d;
      logic stp;

      u_if.rx       = 1'b1;
      u_if.baud_div = 32'd4;
      rst           = 1'b0;
      repeat (3) @(negedge clk);
      check("reset rx_data",   u_if.rx_data,   0);
      check("reset rx_valid",  u_if.rx_valid,  0);
      check("reset frame_err", u_if.frame_err, 0);
      check("reset rx_busy",   u_if.rx_busy,   0);
      rst = 1'b1;
      drive_bit(1'b1, 8);

      vecs[0] = '{8'h55, 1'b1,  4,  4, 1, 0, 8'h55};
      vecs[1] = '{8'hA3, 1'b1,  4,  4, 1, 0, 8'hA3};
      vecs[2] = '{8'h3C, 1'b0,  4,  4, 0, 1, 8'h3C};
      vecs[3] = '{8'h00, 1'b1, 16, 16, 1, 0, 8'h00};
      vecs[4] = '{8'hFF, 1'b1, 16, 16, 1, 0, 8'hFF};
      vecs[5] = '{8'h81, 1'b1,  3,  3, 1, 0, 8'h81};
      vecs[6] = '{8'h5A, 1'b1,  7,  7, 1, 0, 8'h5A};
      vecs[7] = '{8'hC3, 1'b1,  5,  5, 1, 0, 8'hC3};

      for (int v = 0; v < 8; v++) begin
         u_if.baud_div = vecs[v].div;
         drive_bit(1'b1, 3);
         base = obs_q.size();
         send_frame(vecs[v].data, vecs[v].stop, vecs[v].txd);
         if (!vecs[v].stop) drive_bit(1'b0, 20 * vecs[v].txd);
         drive_bit(1'b1, 4 * vecs[v].txd + 4);
         nv = 0;
         nf = 0;
         for (int i = base; i < obs_q.size(); i++) begin
            if (obs_q[i].kind == 1) nv++;
            if (obs_q[i].kind == 2) nf++;
         end
         check($sformatf("vec%0d valid count", v), nv, vecs[v].exp_valid);
         check($sformatf("vec%0d ferr count", v),  nf, vecs[v].exp_ferr);
         check($sformatf("vec%0d rx_data", v), u_if.rx_data, vecs[v].exp_data);
         check($sformatf("vec%0d idle busy", v), u_if.rx_busy, 0);
      end

      // One-cycle glitch must not survive the start-bit re-check.
      u_if.baud_div = 32'd8;
      drive_bit(1'b1, 4);
      s = edge_n; base = obs_q.size();
      drive_bit(1'b0, 1);
      u_if.rx = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (u_if.rx_busy) busy_cnt++;
      end
      check("false start busy window", (busy_cnt >= 1 && busy_cnt <= 6), 1);
      check("false start no strobe", obs_q.size() - base, 0);
      check_segment("false start", s, base);

      u_if.baud_div = 32'd4;
      drive_bit(1'b1, 4);
      s = edge_n; base = obs_q.size();
      send_frame(8'h3C, 1'b0, 4);
      drive_bit(1'b0, 80);
      check("break busy held", u_if.rx_busy, 1);
      check("break one ferr", obs_q.size() - base, 1);
      if (obs_q.size() > base) check("break strobe kind", obs_q[base].kind, 2);
      check("break rx_data", u_if.rx_data, 8'h3C);
      u_if.rx = 1'b1;
      repeat (4) @(negedge clk);
      check("break busy released", u_if.rx_busy, 0);
      drive_bit(1'b1, 40);
      check("break no second frame", obs_q.size() - base, 1);
      check_segment("break", s, base);

      // Abort during data bit 3 of 0xA5.
      drive_bit(1'b1, 4);
      base = obs_q.size();
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 4);
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 4);
      u_if.rx = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("in reset rx_data",   u_if.rx_data,   0);
      check("in reset rx_valid",  u_if.rx_valid,  0);
      check("in reset frame_err", u_if.frame_err, 0);
      check("in reset rx_busy",   u_if.rx_busy,   0);
      @(negedge clk);
      rst = 1'b1;
      drive_bit(1'b1, 40);
      check("aborted frame no strobe", obs_q.size() - base, 0);
      s = edge_n; base = obs_q.size();
      send_frame(8'hF0, 1'b1, 4);
      drive_bit(1'b1, 24);
      check("after reset count", obs_q.size() - base, 1);
      if (obs_q.size() > base) check("after reset data", obs_q[base].data, 8'hF0);
      check_segment("after reset", s, base);

      u_if.baud_div = 32'd16;
      drive_bit(1'b1, 4);
      s = edge_n; base = obs_q.size();
      send_frame(8'h00, 1'b1, 16);
      send_frame(8'hFF, 1'b1, 16);
      send_frame(8'h81, 1'b1, 16);
      drive_bit(1'b1, 64);
      check("b2b count", obs_q.size() - base, 3);
      if (obs_q.size() >= base + 3) begin
         check("b2b data0", obs_q[base].data,   8'h00);
         check("b2b data1", obs_q[base+1].data, 8'hFF);
         check("b2b data2", obs_q[base+2].data, 8'h81);
      end
      check_segment("b2b", s, base);

      // Divider change after start detection must not affect this frame.
      u_if.baud_div = 32'd4;
      drive_bit(1'b1, 4);
      s = edge_n; base = obs_q.size();
      drive_bit(1'b0, 4);
      u_if.baud_div = 32'd10;
      d = 8'h96;
      for (int i = 0; i < 8; i++) drive_bit(d[i], 4);
      drive_bit(1'b1, 30);
      check("div change count", obs_q.size() - base, 1);
      if (obs_q.size() > base) begin
         check("div change kind", obs_q[base].kind, 1);
         check("div change data", obs_q[base].data, 8'h96);
      end
      check_segment("div change", s, base);

      // Every fourth segment programs 0/1 to exercise the divider clamp.
      for (int sg = 0; sg < 12; sg++) begin
         drive_bit(1'b1, 4);
         s = edge_n; base = obs_q.size();
         for (int f = 0; f < 3; f++) begin
            if (sg % 4 == 3) begin
               u_if.baud_div = $urandom_range(0, 1);
               txd = 2;
            end else begin
               dv = $urandom_range(3, 12);
               u_if.baud_div = dv;
               txd = dv;
            end
            d   = 8'($urandom_range(0, 255));
            stp = ($urandom_range(0, 3) != 0);
            send_frame(d, stp, txd);
            if (!stp) begin
               drive_bit(1'b0, $urandom_range(1, 15) * txd);
               drive_bit(1'b1, txd);
            end
            gap = $urandom_range(0, 2) * txd;
            drive_bit(1'b1, gap);
         end
         drive_bit(1'b1, 80);
         check_segment($sformatf("rand seg%0d", sg), s, base);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
